// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//  rx_state_e  receiver FSM states
//  PAR_EVEN/PAR_ODD  parity type encodings as seen on PAR_TYP
//  DATA_BITS   payload width of one frame
//  exp_parity  parity bit the transmitter should have sent for a byte
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } rx_state_e;

  function automatic logic exp_parity(input logic [DATA_BITS-1:0] data, input logic par_typ);
    return (^data) ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: bundles the serial line, frame configuration and the byte/status strobes
// of the UART receiver.
//  master: drives RX_IN, PAR_EN, PAR_TYP; observes the receiver outputs
//  slave : the receiver itself
// With UART_RX_BREAK_DET_EN defined the bundle also carries break_det.
interface uart_rx_frame_if;
  import uart_pkg::*;

  logic                 RX_IN;
  logic                 PAR_EN;
  logic                 PAR_TYP;
  logic [DATA_BITS-1:0] P_DATA;
  logic                 data_valid;
  logic                 par_err;
  logic                 stp_err;
  logic                 busy;
`ifdef UART_RX_BREAK_DET_EN
  logic                 break_det;
`endif

  modport master (
    output RX_IN, PAR_EN, PAR_TYP,
`ifdef UART_RX_BREAK_DET_EN
    input  break_det,
`endif
    input  P_DATA, data_valid, par_err, stp_err, busy
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP,
`ifdef UART_RX_BREAK_DET_EN
    output break_det,
`endif
    output P_DATA, data_valid, par_err, stp_err, busy
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: synchronizes the serial line and produces per-bit timing and a 2-of-3
// majority-voted bit value.
//  clk_i, rst_i     clock, synchronous active-high reset
//  rx_i             raw serial line
//  en_i             bit timing runs while high; edge counter held at 0 otherwise
//  rx_sync_o        synchronized line
//  bit_val_o        majority of samples at mid-1, mid, mid+1 (valid with sample_strobe_o)
//  sample_strobe_o  high in the cycle edge_cnt == mid+1
//  bit_end_o        high in the cycle edge_cnt == OVERSAMPLE-1
module uart_rx_sampler #(
  parameter int unsigned OVERSAMPLE  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  input  logic en_i,
  output logic rx_sync_o,
  output logic bit_val_o,
  output logic sample_strobe_o,
  output logic bit_end_o
);

  if (OVERSAMPLE < 4 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_sampler: OVERSAMPLE must be even and in 4..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("uart_rx_sampler: SYNC_STAGES must be >= 2");
  end

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned Mid  = OVERSAMPLE / 2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [1:0]             samp_q, samp_d;  // [0] at mid-1, [1] at mid
  logic                   rx_sync;

  assign rx_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d  = '0;
    samp_d = samp_q;
    if (en_i) begin
      cnt_d = (cnt_q == CntW'(OVERSAMPLE - 1)) ? '0 : cnt_q + CntW'(1);
      if (cnt_q == CntW'(Mid - 1)) samp_d[0] = rx_sync;
      if (cnt_q == CntW'(Mid))     samp_d[1] = rx_sync;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;  // line idles high
      cnt_q  <= '0;
      samp_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      cnt_q  <= cnt_d;
      samp_q <= samp_d;
    end
  end

  // Third sample is the live synchronized line at mid+1.
  assign bit_val_o = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync) | (samp_q[1] & rx_sync);
  assign sample_strobe_o = en_i && (cnt_q == CntW'(Mid + 1));
  assign bit_end_o       = en_i && (cnt_q == CntW'(OVERSAMPLE - 1));
  assign rx_sync_o       = rx_sync;

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receiver. Recovers start / 8 data (LSB first) / optional parity / stop
// frames from an oversampled serial line and reports each good byte as a one-cycle strobe.
//  clk, rst   clock, synchronous active-high reset
//  bus        uart_rx_frame_if.slave:
//               RX_IN, PAR_EN, PAR_TYP in; P_DATA, data_valid, par_err, stp_err, busy out
// Optional: define UART_RX_BREAK_DET_EN to add break_det; an all-zero frame with a missing
// stop bit then pulses break_det instead of stp_err/par_err.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_frame_if.slave  bus
);

  rx_state_e            state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] pdata_q, pdata_d;
  logic                 par_en_q, par_en_d;
  logic                 par_typ_q, par_typ_d;
  logic                 par_bad_q, par_bad_d;
  logic                 valid_q, valid_d;
  logic                 par_err_q, par_err_d;
  logic                 stp_err_q, stp_err_d;
`ifdef UART_RX_BREAK_DET_EN
  logic                 brk_q, brk_d;
`endif

  logic rx_sync, bit_val, sample_strobe, bit_end, timing_en;

  assign timing_en = (state_q == StStart) || (state_q == StData) ||
                     (state_q == StParity) || (state_q == StStop);

  uart_rx_sampler #(
    .OVERSAMPLE  (OVERSAMPLE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk_i           (clk),
    .rst_i           (rst),
    .rx_i            (bus.RX_IN),
    .en_i            (timing_en),
    .rx_sync_o       (rx_sync),
    .bit_val_o       (bit_val),
    .sample_strobe_o (sample_strobe),
    .bit_end_o       (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pdata_d   = pdata_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_bad_d = par_bad_q;
    valid_d   = 1'b0;
    par_err_d = 1'b0;
    stp_err_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    brk_d     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rx_sync) begin
          state_d   = StStart;
          bit_cnt_d = '0;
          par_bad_d = 1'b0;
          par_en_d  = bus.PAR_EN;   // configuration frozen for the whole frame
          par_typ_d = bus.PAR_TYP;
        end
      end
      StStart: begin
        if (sample_strobe && bit_val) state_d = StIdle;  // glitch, not a real start bit
        else if (bit_end)             state_d = StData;
      end
      StData: begin
        if (sample_strobe) begin
          shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        if (bit_end && bit_cnt_q == 4'(DATA_BITS)) begin
          state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: begin
        if (sample_strobe) par_bad_d = (bit_val != exp_parity(shift_q, par_typ_q));
        if (bit_end)       state_d   = StStop;
      end
      StStop: begin
        // Leave at mid-stop so a back-to-back start edge is never missed.
        if (sample_strobe) begin
          if (bit_val) begin
            state_d = StIdle;
            if (par_bad_q) begin
              par_err_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              pdata_d = shift_q;
            end
          end else begin
            state_d = StWaitIdle;
`ifdef UART_RX_BREAK_DET_EN
            if (shift_q == '0) begin
              brk_d = 1'b1;
            end else begin
              stp_err_d = 1'b1;
              par_err_d = par_bad_q;
            end
`else
            stp_err_d = 1'b1;
            par_err_d = par_bad_q;
`endif
          end
        end
      end
      StWaitIdle: begin
        if (rx_sync) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      pdata_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad_q <= 1'b0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      pdata_q   <= pdata_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_bad_q <= par_bad_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
`ifdef UART_RX_BREAK_DET_EN
      brk_q     <= brk_d;
`endif
    end
  end

  assign bus.P_DATA     = pdata_q;
  assign bus.data_valid = valid_q;
  assign bus.par_err    = par_err_q;
  assign bus.stp_err    = stp_err_q;
  assign bus.busy       = (state_q != StIdle);
`ifdef UART_RX_BREAK_DET_EN
  assign bus.break_det  = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frames on RX_IN; expected strobes go into a scoreboard queue and a
// negedge monitor pops and compares each time the receiver raises any strobe.
module tb_uart_rx_frame;

  localparam int unsigned Os = 8;

  typedef struct packed {
    logic [3:0] pulses;  // {break_det, stp_err, par_err, data_valid}
    logic [7:0] pdata;
  } ev_t;

  localparam logic [3:0] PValid = 4'b0001;
  localparam logic [3:0] PPar   = 4'b0010;
  localparam logic [3:0] PStp   = 4'b0100;
  localparam logic [3:0] PBrk   = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_frame_if u_if ();

  uart_rx_frame #(
    .OVERSAMPLE  (Os),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  ev_t  sb_q[$];
  logic [7:0] exp_pdata = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [3:0] pulses, input logic [7:0] data);
    if (pulses == PValid) exp_pdata = data;
    sb_q.push_back('{pulses: pulses, pdata: exp_pdata});
  endtask

  task automatic send_bit(input logic b);
    u_if.RX_IN = b;
    repeat (Os) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic with_par, input logic par_bit,
                            input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (with_par) send_bit(par_bit);
    send_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    u_if.RX_IN = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " P_DATA"},     32'(u_if.P_DATA), 32'h00);
    check({tag, " data_valid"}, 32'(u_if.data_valid), 32'h0);
    check({tag, " par_err"},    32'(u_if.par_err), 32'h0);
    check({tag, " stp_err"},    32'(u_if.stp_err), 32'h0);
    check({tag, " busy"},       32'(u_if.busy), 32'h0);
  endtask

  // Monitor: every strobe cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [3:0] seen;
    ev_t        e;
    seen = {1'b0, u_if.stp_err, u_if.par_err, u_if.data_valid};
`ifdef UART_RX_BREAK_DET_EN
    seen[3] = u_if.break_det;
`endif
    if (!rst && seen != 4'b0000) begin
      if (sb_q.size() == 0) begin
        check("unexpected strobe", 32'(seen), 32'h0);
      end else begin
        e = sb_q.pop_front();
        check("strobe set", 32'(seen), 32'(e.pulses));
        check("P_DATA at strobe", 32'(u_if.P_DATA), 32'(e.pdata));
      end
    end
  end

  initial begin
    bit seen_busy;
    u_if.RX_IN   = 1'b1;
    u_if.PAR_EN  = 1'b0;
    u_if.PAR_TYP = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    idle(10);

    // 1: reset in the middle of a frame discards it; a clean frame follows.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("busy mid-frame", 32'(u_if.busy), 32'h1);
    rst = 1'b1;
    u_if.RX_IN = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("reset mid-frame");
    rst = 1'b0;
    idle(20);
    expect_ev(PValid, 8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    idle(20);

    // 2: even parity, 0xA5 has four ones -> parity bit 0 is correct.
    u_if.PAR_EN  = 1'b1;
    u_if.PAR_TYP = 1'b0;
    expect_ev(PValid, 8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    idle(20);

    // 3: odd parity, 0x5A has four ones -> correct bit is 1, so 0 is a mismatch.
    u_if.PAR_TYP = 1'b1;
    expect_ev(PPar, 8'h00);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
    idle(20);

    // 4: no parity, two frames with no gap between stop and next start.
    u_if.PAR_EN  = 1'b0;
    u_if.PAR_TYP = 1'b0;
    expect_ev(PValid, 8'hB7);
    expect_ev(PValid, 8'h01);
    send_frame(8'hB7, 1'b0, 1'b0, 1'b1);
    send_frame(8'h01, 1'b0, 1'b0, 1'b1);
    idle(20);

    // 5: two-cycle low glitch must be rejected in START.
    u_if.RX_IN = 1'b0;
    repeat (2) @(negedge clk);
    u_if.RX_IN = 1'b1;
    seen_busy = 1'b0;
    for (int i = 0; i < 12 && !seen_busy; i++) begin
      @(negedge clk);
      if (u_if.busy) seen_busy = 1'b1;
    end
    check("glitch busy rises", 32'(seen_busy), 32'h1);
    for (int i = 0; i < 20 && u_if.busy; i++) @(negedge clk);
    check("glitch busy drops", 32'(u_if.busy), 32'h0);
    idle(10);
    expect_ev(PValid, 8'h55);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    idle(20);

    // 6: all-zero frame with the line stuck low past the stop bit.
`ifdef UART_RX_BREAK_DET_EN
    expect_ev(PBrk, 8'h00);
`else
    expect_ev(PStp, 8'h00);
`endif
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b0);
    repeat (40) @(negedge clk);
    check("busy while line low", 32'(u_if.busy), 32'h1);
    idle(10);
    check("busy after line high", 32'(u_if.busy), 32'h0);
    idle(20);

    check("outstanding expectations", 32'(sb_q.size()), 32'h0);
    check("final P_DATA", 32'(u_if.P_DATA), 32'h55);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
